vga_fetch_ctrl: RTL
===================

# vga_fetch_ctrl

Sequencer between the SDRAM frame-buffer reader and the 640x480@60 VGA timing generator. Owns the `start` line of the timing generator and mirrors its 800x525 counters. Issues per-pixel FIFO reads so the 1-bit `etch` stream lands exactly in the 320x160 window. Schedules SDRAM burst refills of the pixel FIFO and flags underflow.

## Interface
Parameters:
- H_TOTAL, 800, pixel clocks per line
- V_TOTAL, 525, lines per frame
- WIN_X0 / WIN_X1, 143 / 462, first/last window column (inclusive, 320 px)
- WIN_Y0 / WIN_Y1, 36 / 195, first/last window line (inclusive, 160 lines)
- LVL_W, 11, FIFO level width
- PREFILL, 512, FIFO level required before display starts
- LOW_MARK, 768, refill requested while level below this
- BURST_LEN, 64, bits per SDRAM burst; must divide 51200

Ports:
- clk_vga  in  1  pixel clock
- rst_mix  in  1  reset, asynchronous, active-high
- en  in  1  display enable, level
- fifo_level  in  LVL_W  current pixel FIFO occupancy (bits)
- fifo_empty  in  1  pixel FIFO empty
- fifo_rd  out  1  FIFO read strobe; data valid on `etch` next cycle
- vga_start  out  1  drives timing generator `start`
- burst_req  out  1  SDRAM burst request
- burst_ack  in  1  request accepted, single-cycle pulse
- burst_done  in  1  burst data fully written to FIFO, single-cycle pulse
- frame_start  out  1  one-cycle pulse when mirror counters are at (0,0) in RUN
- underflow  out  1  sticky: read needed while FIFO empty
- clr_err  in  1  clears `underflow`
- state  out  2  current state, for debug

## Operation
- States: IDLE=0, PREFILL=1, RUN=2, STOP=3.
- IDLE: `vga_start`=0; mirror counters h, v held at 0; burst counter cleared. Go to PREFILL when `en`=1.
- PREFILL: bursts allowed. Go to RUN when `fifo_level` >= PREFILL. `vga_start` rises on the same edge that enters RUN.
- PREFILL with `en`=0: return to IDLE. An outstanding burst still completes.
- RUN: `vga_start`=1. Mirror h increments every cycle and wraps at H_TOTAL-1. v increments when h wraps and itself wraps at V_TOTAL-1. This matches the timing generator edge for edge.
- RUN with `en`=0: go to STOP.
- STOP: keep `vga_start`=1 and keep counting until h=H_TOTAL-1 and v=V_TOTAL-1. On that edge counters go to 0, `vga_start` goes to 0 and the state becomes IDLE. `vga_start` never drops mid-frame.
- Read window: raw read = RUN/STOP and v in [WIN_Y0, WIN_Y1] and h+1 in [WIN_X0, WIN_X1]. This gives 51200 reads per frame.
- `fifo_rd` = raw read AND NOT `fifo_empty`.
- Raw read while `fifo_empty`=1 sets `underflow`. `clr_err` clears it. If set and clear happen in the same cycle, set wins.
- Burst scheduler: at most one burst outstanding.
  - `burst_req` rises when: state is PREFILL, RUN or STOP; no burst outstanding; `fifo_level` < LOW_MARK; and bursts issued this frame < 51200/BURST_LEN.
  - `burst_req` holds until `burst_ack`, then drops the next cycle. Outstanding stays set until `burst_done`.
  - The issued-burst counter increments on `burst_ack`. It resets on `frame_start`, and in IDLE.
  - In PREFILL the frame cap applies to the first frame.
  - If `burst_ack` and `burst_done` arrive in the same cycle, treat it as a completed burst with nothing outstanding.

## Timing
- Reset values: `fifo_rd`=0, `vga_start`=0, `burst_req`=0, `frame_start`=0, `underflow`=0, `state`=IDLE; h=v=0; burst counter = 0; outstanding = 0.
- All outputs are registered except `fifo_rd`. `fifo_rd` is combinational from registered counters and `fifo_empty`.
- The FIFO read latency is 1 cycle. The pixel consumed at timing-generator count h was read at h-1.
- `frame_start` is high in the cycle where h=0 and v=0 and state is RUN or STOP. That includes the first RUN cycle.
- Asserting reset mid-operation returns everything to reset values immediately. The external FIFO is flushed by its own reset.

## Structure
- Shared package `vga_pkg`: state encoding, H_TOTAL/V_TOTAL, the window constants, and FRAME_BITS=51200. These are shared with the timing generator.
- Natural sub-module: `burst_sched` (request/ack/done handshake, outstanding flag, per-frame burst counter).
- The top module holds the FSM, mirror counters, read-window decode and underflow flag.

## Test plan
- Reset, `en`=1, `fifo_level` ramps to 512 -> RUN entered, `vga_start` rises on that edge, `frame_start` pulses in the first RUN cycle.
- Steady RUN with a FIFO model that never empties -> exactly 51200 `fifo_rd` per frame. The first read is at (h=142, v=36), the last at (h=461, v=195). `underflow` stays 0.
- Force `fifo_empty`=1 at (h=200, v=100) -> no `fifo_rd` that cycle, `underflow`=1. It stays set until a `clr_err` pulse.
- Burst handshake with `burst_ack` 5 cycles after request and `burst_done` 70 cycles later -> exactly one `burst_req` per burst. There are 800 acks per frame, and no request while a burst is outstanding.
- `en` dropped at (h=300, v=250) -> `vga_start` stays 1 until the edge after (799,524), then 0, and `state`=IDLE.
- Reset asserted mid-RUN at (h=400, v=120) -> all outputs 0 asynchronously. Restart from IDLE behaves as the first scenario.

Source files
------------

// File: rtl/vga_pkg.sv
// Constants and state encoding shared by the VGA fetch sequencer and the timing generator.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2,
    ST_STOP    = 2'd3
  } state_t;

  localparam int unsigned VGA_H_TOTAL    = 800;
  localparam int unsigned VGA_V_TOTAL    = 525;
  localparam int unsigned VGA_WIN_X0     = 143;
  localparam int unsigned VGA_WIN_X1     = 462;
  localparam int unsigned VGA_WIN_Y0     = 36;
  localparam int unsigned VGA_WIN_Y1     = 195;
  localparam int unsigned VGA_FRAME_BITS = 51200;
  localparam int unsigned VGA_LVL_W      = 11;
  localparam int unsigned VGA_PREFILL    = 512;
  localparam int unsigned VGA_LOW_MARK   = 768;
  localparam int unsigned VGA_BURST_LEN  = 64;

endpackage

// File: rtl/burst_sched.sv
// SDRAM burst refill scheduler: one outstanding burst at most, capped per frame.
module burst_sched #(
  parameter int unsigned LVL_W      = 11,
  parameter int unsigned LOW_MARK   = 768,
  parameter int unsigned MAX_BURSTS = 800
) (
  input  logic             clk_vga,
  input  logic             rst_mix,
  input  logic             idle,
  input  logic             frame_wrap,
  input  logic [LVL_W-1:0] fifo_level,
  input  logic             burst_ack,
  input  logic             burst_done,
  output logic             burst_req
);

  localparam int unsigned CW = $clog2(MAX_BURSTS + 1);

  logic          outst;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_vga or posedge rst_mix) begin
    if (rst_mix) begin
      burst_req <= 1'b0;
      outst     <= 1'b0;
      cnt       <= '0;
    end else begin
      // A pending request is held through IDLE so the handshake always closes
      if (burst_req) begin
        if (burst_ack) burst_req <= 1'b0;
      end else if (!idle && !outst && (fifo_level < LVL_W'(LOW_MARK)) &&
                   (cnt < CW'(MAX_BURSTS))) begin
        burst_req <= 1'b1;
      end

      if (burst_ack && !burst_done) outst <= 1'b1;
      else if (burst_done)          outst <= 1'b0;

      // Prefill bursts are charged to the first frame, so only a wrap clears the count
      if (idle)            cnt <= '0;
      else if (frame_wrap) cnt <= burst_ack ? CW'(1) : '0;
      else if (burst_ack)  cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/vga_fetch_ctrl.sv
// Sequencer between the frame-buffer FIFO and the VGA timing generator: start control,
// mirror counters, window read strobes, underflow flag and burst scheduling.
module vga_fetch_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_TOTAL   = VGA_H_TOTAL,
  parameter int unsigned V_TOTAL   = VGA_V_TOTAL,
  parameter int unsigned WIN_X0    = VGA_WIN_X0,
  parameter int unsigned WIN_X1    = VGA_WIN_X1,
  parameter int unsigned WIN_Y0    = VGA_WIN_Y0,
  parameter int unsigned WIN_Y1    = VGA_WIN_Y1,
  parameter int unsigned LVL_W     = VGA_LVL_W,
  parameter int unsigned PREFILL   = VGA_PREFILL,
  parameter int unsigned LOW_MARK  = VGA_LOW_MARK,
  parameter int unsigned BURST_LEN = VGA_BURST_LEN
) (
  input  logic             clk_vga,
  input  logic             rst_mix,
  input  logic             en,
  input  logic [LVL_W-1:0] fifo_level,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic             vga_start,
  output logic             burst_req,
  input  logic             burst_ack,
  input  logic             burst_done,
  output logic             frame_start,
  output logic             underflow,
  input  logic             clr_err,
  output logic [1:0]       state
);

  localparam int unsigned HW         = $clog2(H_TOTAL);
  localparam int unsigned VW         = $clog2(V_TOTAL);
  localparam int unsigned WIN_BITS   = (WIN_X1 - WIN_X0 + 1) * (WIN_Y1 - WIN_Y0 + 1);
  localparam int unsigned MAX_BURSTS = WIN_BITS / BURST_LEN;

  state_t        st_q;
  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;
  logic          frame_wrap_q;
  logic          h_last;
  logic          v_last;
  logic          counting;
  logic          raw_rd;
  logic [HW:0]   h_p1;

  assign h_last   = (h_q == HW'(H_TOTAL - 1));
  assign v_last   = (v_q == VW'(V_TOTAL - 1));
  assign counting = (st_q == ST_RUN) || (st_q == ST_STOP);
  assign h_p1     = (HW+1)'(h_q) + (HW+1)'(1);

  // Read one column ahead: the pixel shown at h was fetched at h-1
  assign raw_rd = counting &&
                  (v_q  >= VW'(WIN_Y0))     && (v_q  <= VW'(WIN_Y1)) &&
                  (h_p1 >= (HW+1)'(WIN_X0)) && (h_p1 <= (HW+1)'(WIN_X1));

  assign fifo_rd = raw_rd && !fifo_empty;
  assign state   = st_q;

  always_ff @(posedge clk_vga or posedge rst_mix) begin
    if (rst_mix) begin
      st_q         <= ST_IDLE;
      h_q          <= '0;
      v_q          <= '0;
      vga_start    <= 1'b0;
      frame_start  <= 1'b0;
      frame_wrap_q <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      frame_start  <= 1'b0;
      frame_wrap_q <= 1'b0;

      if (counting) begin
        h_q <= h_last ? '0 : h_q + HW'(1);
        if (h_last) v_q <= v_last ? '0 : v_q + VW'(1);
      end

      case (st_q)
        ST_IDLE: begin
          vga_start <= 1'b0;
          h_q       <= '0;
          v_q       <= '0;
          if (en) st_q <= ST_PREFILL;
        end
        ST_PREFILL: begin
          if (!en) begin
            st_q <= ST_IDLE;
          end else if (fifo_level >= LVL_W'(PREFILL)) begin
            st_q        <= ST_RUN;
            vga_start   <= 1'b1;
            frame_start <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!en) st_q <= ST_STOP;
          if (h_last && v_last) begin
            frame_start  <= 1'b1;
            frame_wrap_q <= 1'b1;
          end
        end
        ST_STOP: begin
          // Only release the timing generator at the frame boundary
          if (h_last && v_last) begin
            st_q      <= ST_IDLE;
            vga_start <= 1'b0;
          end
        end
        default: st_q <= ST_IDLE;
      endcase

      if (raw_rd && fifo_empty) underflow <= 1'b1;
      else if (clr_err)         underflow <= 1'b0;
    end
  end

  burst_sched #(
    .LVL_W      (LVL_W),
    .LOW_MARK   (LOW_MARK),
    .MAX_BURSTS (MAX_BURSTS)
  ) u_burst_sched (
    .clk_vga    (clk_vga),
    .rst_mix    (rst_mix),
    .idle       (st_q == ST_IDLE),
    .frame_wrap (frame_wrap_q),
    .fifo_level (fifo_level),
    .burst_ack  (burst_ack),
    .burst_done (burst_done),
    .burst_req  (burst_req)
  );

endmodule
